image_dither_sequencer: RTL and testbench
=========================================

// Module: image_dither_sequencer
// PURPOSE
//  Front-end controller for image_dither. Accepts the camera-style stream (vsync/hsync framed, 1 px/clk while hsync high).
//  Tracks x/y position and emits aligned pixel-valid and kernel-border flags so the dither core can gate out-of-image error taps.
//  Schedules a per-line drain window and ping-pongs the error line-buffer bank. Detects malformed line/frame geometry.
// PARAMETERS
//  PIXWIDTH     8    pixel width passed through
//  IMAGE_WIDTH  320  active pixels per line
//  IMAGE_HEIGHT 240  active lines per frame
//  PIPE_DEPTH   2    drain cycles the dither core needs after the last pixel of a line (>=1)
//  XW / YW      $clog2(IMAGE_WIDTH) / $clog2(IMAGE_HEIGHT)   derived counter widths; do not override
// PORTS
//  clk            in   1         single clock, all logic posedge
//  reset          in   1         synchronous, active-high
//  vsync_in       in   1         high for whole frame
//  hsync_in       in   1         high while line pixels valid
//  pix_in         in   PIXWIDTH  pixel, sampled when hsync_in high
//  pix_valid      out  1         pixel issued to dither core
//  pix_out        out  PIXWIDTH  pix_in delayed 1 cycle
//  x / y          out  XW / YW   position of pix_out
//  first_col, last_col, first_row, last_row  out 1 each   border flags, aligned with pix_valid
//  drain          out  1         high for PIPE_DEPTH cycles after each issued line
//  err_bank       out  1         error line-buffer bank for the current line; toggles at line end
//  line_done      out  1         1-cycle pulse at end of drain or skipped line
//  frame_done     out  1         1-cycle pulse at frame end
//  err_line_short, err_line_long, err_frame_short, err_frame_long, err_overrun   out 1 each   1-cycle status pulses
// BEHAVIOUR
//  - Reset: all outputs 0, x=y=0, err_bank=0, state IDLE. Reset mid-frame discards the rest of that frame.
//  - Edges: hsync/vsync rise and fall come from registered previous value vs current input. The first hsync-high cycle is pixel 0.
//  - Latency: pix_out, pix_valid, x, y and flags are registered 1 cycle after the pix_in sample.
//  - IDLE: wait for vsync rise. vsync already high out of reset is ignored. On the rise: y=0 -> WAIT.
//  - WAIT: on hsync rise -> LINE, issue pixel 0.
//    On vsync fall: if y!=IMAGE_HEIGHT pulse err_frame_short. Pulse frame_done. -> IDLE.
//  - LINE: each hsync-high cycle with x<IMAGE_WIDTH issues a pixel (pix_valid=1), then x++.
//    Extra pixels: pix_valid=0 and err_line_long pulses once per line.
//    On hsync fall: err_line_short if fewer than IMAGE_WIDTH pixels were issued. -> DRAIN.
//  - LINE and vsync fall: handled as hsync fall (incl. same cycle). Go through DRAIN, then frame-end handling as in WAIT.
//  - DRAIN: drain=1 for exactly PIPE_DEPTH cycles. On the last cycle: line_done pulse, err_bank toggles, y++ -> WAIT
//    (-> IDLE path if vsync has fallen).
//  - hsync rise during DRAIN: err_overrun pulse; drain completes normally.
//    The overlapping line goes to SKIP: pix_valid=0 until hsync fall, then line_done, err_bank toggle, y++.
//  - Lines with y>=IMAGE_HEIGHT: SKIP behaviour. err_frame_long pulses once per frame. y saturates at IMAGE_HEIGHT.
//  - Flags: first_col=(x==0), last_col=(x==IMAGE_WIDTH-1), first_row=(y==0), last_row=(y==IMAGE_HEIGHT-1). Flags are 0 when pix_valid=0.
//  - Counters never wrap; x saturates at IMAGE_WIDTH.
// STRUCTURE
//  - image_dither_pkg: seq_state_t enum {IDLE, WAIT, LINE, DRAIN, SKIP}; error-vector bit indices.
//  - Sub-module sync_edge_detect (registered rise/fall pulses) instantiated for hsync_in and vsync_in.
//  - Remainder: one FSM, x/y/drain counters, output registers.
// TESTING (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, PIPE_DEPTH=2)
//  1 Nominal frame, 4 lines x 8 px:
//    -> 8 pix_valid per line, x 0..7; last_col only at x=7.
//    -> drain 2 cycles after each hsync fall, then line_done.
//    -> err_bank 0,1,0,1; last_row on y=3; frame_done on vsync fall; no error pulses.
//  2 Line of 5 px -> 5 pix_valid, err_line_short pulse, drain still 2 cycles, y advances.
//  3 Line of 10 px -> 8 pix_valid, single err_line_long pulse, no valid at pixels 8-9.
//  4 hsync rise 1 cycle after hsync fall -> err_overrun, second line gives 0 pix_valid, both lines advance y (+2).
//  5 Frame with 3 lines then vsync fall -> err_frame_short + frame_done. Frame with 5 lines -> line 5 issues no pixels, one err_frame_long.
//  6 reset asserted at x=4 -> all outputs 0 next cycle. No pix_valid until the next vsync rise and hsync rise.

Source files
------------

// File: rtl/image_dither_pkg.sv
// -----------------------------------------------------------------------------
// image_dither_pkg
// Shared types for the image_dither front-end sequencer:
//   seq_state_t  - sequencer FSM states
//   ERR_*        - bit positions inside the packed status-pulse vector
// -----------------------------------------------------------------------------
package image_dither_pkg;

   typedef enum logic [2:0] {
      IDLE,   // waiting for the start of a frame
      WAIT,   // inside a frame, between lines
      LINE,   // issuing pixels of an active line
      DRAIN,  // flushing the dither pipeline after a line
      SKIP    // swallowing a line that must not be issued
   } seq_state_t;

   localparam int ERR_LINE_SHORT  = 0;
   localparam int ERR_LINE_LONG   = 1;
   localparam int ERR_FRAME_SHORT = 2;
   localparam int ERR_FRAME_LONG  = 3;
   localparam int ERR_OVERRUN     = 4;
   localparam int ERR_W           = 5;

   typedef logic [ERR_W-1:0] err_vec_t;

endpackage : image_dither_pkg

// File: rtl/image_dither_sequencer_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Compares the current level of a synchronous strobe with its value from the
// previous cycle and reports rising / falling edges in the same cycle as the
// new level, so the first high cycle of a strobe can be acted on directly.
//
// Ports
//   clk     in   clock
//   i_sig   in   strobe level (already synchronous to clk)
//   o_rise  out  i_sig high now, low last cycle
//   o_fall  out  i_sig low now, high last cycle
// -----------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;

   // The history register deliberately has no reset: it always tracks the
   // input, so a level that is already high when reset releases is not seen
   // as an edge.
   // NOTE: clocked state is assigned with <= so every register samples the
   // pre-edge values of the others; blocking = here would create order races.
   always_ff @(posedge clk) begin
      r_prev <= i_sig;
   end

   assign o_rise = i_sig & ~r_prev;
   assign o_fall = ~i_sig & r_prev;

endmodule : sync_edge_detect

// File: rtl/image_dither_sequencer.sv
// -----------------------------------------------------------------------------
// image_dither_sequencer
// Front-end controller for the image_dither core. Follows a vsync/hsync framed
// stream (1 px/clk while hsync is high), issues pixels with their x/y position
// and kernel-border flags, opens a drain window after each issued line,
// ping-pongs the error line-buffer bank and flags malformed geometry.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   vsync_in            high for the whole frame
//   hsync_in            high while line pixels are valid
//   pix_in              pixel sampled while hsync_in is high
//   pix_valid           pixel issued to the dither core
//   pix_out             pix_in delayed one cycle
//   x, y                position of the issued pixel (held between pixels)
//   first_col/last_col/first_row/last_row   border flags, 0 unless pix_valid
//   drain               high PIPE_DEPTH cycles after each issued line
//   err_bank            error line-buffer bank, toggles at each line end
//   line_done           pulse when a line (issued or skipped) is retired
//   frame_done          pulse at frame end
//   err_line_short, err_line_long, err_frame_short, err_frame_long,
//   err_overrun         one-cycle status pulses
// -----------------------------------------------------------------------------
module image_dither_sequencer
   import image_dither_pkg::*;
#(
   parameter int PIXWIDTH     = 8,
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int PIPE_DEPTH   = 2,
   parameter int XW           = $clog2(IMAGE_WIDTH),
   parameter int YW           = $clog2(IMAGE_HEIGHT)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vsync_in,
   input  logic                hsync_in,
   input  logic [PIXWIDTH-1:0] pix_in,
   output logic                pix_valid,
   output logic [PIXWIDTH-1:0] pix_out,
   output logic [XW-1:0]       x,
   output logic [YW-1:0]       y,
   output logic                first_col,
   output logic                last_col,
   output logic                first_row,
   output logic                last_row,
   output logic                drain,
   output logic                err_bank,
   output logic                line_done,
   output logic                frame_done,
   output logic                err_line_short,
   output logic                err_line_long,
   output logic                err_frame_short,
   output logic                err_frame_long,
   output logic                err_overrun
);

   // Counters need one value beyond the last index so they can saturate at
   // IMAGE_WIDTH / IMAGE_HEIGHT; the x/y ports only carry valid positions.
   localparam int XCW = $clog2(IMAGE_WIDTH + 1);
   localparam int YCW = $clog2(IMAGE_HEIGHT + 1);
   localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   localparam logic [XCW-1:0] X_END  = XCW'(IMAGE_WIDTH);
   localparam logic [XCW-1:0] X_LAST = XCW'(IMAGE_WIDTH - 1);
   localparam logic [YCW-1:0] Y_END  = YCW'(IMAGE_HEIGHT);
   localparam logic [YCW-1:0] Y_LAST = YCW'(IMAGE_HEIGHT - 1);
   localparam logic [DCW-1:0] D_LAST = DCW'(PIPE_DEPTH - 1);

   // ---------------------------------------------------------------- edges
   logic w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;

   sync_edge_detect u_hsync_edge (
      .clk    (clk),
      .i_sig  (hsync_in),
      .o_rise (w_hs_rise),
      .o_fall (w_hs_fall)
   );

   sync_edge_detect u_vsync_edge (
      .clk    (clk),
      .i_sig  (vsync_in),
      .o_rise (w_vs_rise),
      .o_fall (w_vs_fall)
   );

   // ---------------------------------------------------------------- state
   seq_state_t          r_state,  w_state;
   logic [XCW-1:0]      r_x_cnt,  w_x_cnt;
   logic [YCW-1:0]      r_y_cnt,  w_y_cnt;
   logic [DCW-1:0]      r_d_cnt,  w_d_cnt;
   logic                r_line_long_seen,  w_line_long_seen;
   logic                r_frame_long_seen, w_frame_long_seen;
   logic                r_overrun_pend,    w_overrun_pend;
   logic                r_vs_fell,         w_vs_fell;
   logic                r_bank,   w_bank;
   logic                r_drain,  w_drain;
   logic                r_line_done,  w_line_done;
   logic                r_frame_done, w_frame_done;
   err_vec_t            r_err,    w_err;
   logic                w_issue;

   // Output registers for the issued pixel.
   logic                r_pix_valid;
   logic [PIXWIDTH-1:0] r_pix_out;
   logic [XW-1:0]       r_x;
   logic [YW-1:0]       r_y;
   logic                r_first_col, r_last_col, r_first_row, r_last_row;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state           = r_state;
      w_x_cnt           = r_x_cnt;
      w_y_cnt           = r_y_cnt;
      w_d_cnt           = r_d_cnt;
      w_line_long_seen  = r_line_long_seen;
      w_frame_long_seen = r_frame_long_seen;
      w_overrun_pend    = r_overrun_pend;
      w_vs_fell         = r_vs_fell | w_vs_fall;  // remembered until frame end
      w_bank            = r_bank;
      w_drain           = 1'b0;
      w_line_done       = 1'b0;
      w_frame_done      = 1'b0;
      w_err             = '0;
      w_issue           = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_vs_fell = 1'b0;
            if (w_vs_rise) begin
               w_y_cnt           = '0;
               w_frame_long_seen = 1'b0;
               w_overrun_pend    = 1'b0;
               w_state           = WAIT;
            end
         end

         WAIT: begin
            // Frame end takes priority over a line starting in the same cycle.
            if (w_vs_fell) begin
               if (r_y_cnt != Y_END) w_err[ERR_FRAME_SHORT] = 1'b1;
               w_frame_done = 1'b1;
               w_vs_fell    = 1'b0;
               w_state      = IDLE;
            end else if (w_hs_rise) begin
               w_line_long_seen = 1'b0;
               if (r_y_cnt >= Y_END) begin
                  // Surplus line: swallow it, report once per frame.
                  if (!r_frame_long_seen) w_err[ERR_FRAME_LONG] = 1'b1;
                  w_frame_long_seen = 1'b1;
                  w_state           = SKIP;
               end else begin
                  // r_x_cnt is 0 here, so this issues pixel 0.
                  w_issue = 1'b1;
                  w_x_cnt = r_x_cnt + XCW'(1);
                  w_state = LINE;
               end
            end
         end

         LINE: begin
            // A vsync fall closes the line exactly like an hsync fall.
            if (w_hs_fall || w_vs_fall) begin
               if (r_x_cnt < X_END) w_err[ERR_LINE_SHORT] = 1'b1;
               w_x_cnt = '0;
               w_d_cnt = '0;
               w_drain = 1'b1;
               w_state = DRAIN;
            end else if (r_x_cnt < X_END) begin
               w_issue = 1'b1;
               w_x_cnt = r_x_cnt + XCW'(1);
            end else begin
               if (!r_line_long_seen) w_err[ERR_LINE_LONG] = 1'b1;
               w_line_long_seen = 1'b1;
            end
         end

         DRAIN: begin
            // A new line starting inside the drain window cannot be issued;
            // the window still runs to completion.
            if (w_hs_rise) begin
               w_err[ERR_OVERRUN] = 1'b1;
               w_overrun_pend     = 1'b1;
            end
            if (r_d_cnt == D_LAST) begin
               w_line_done = 1'b1;
               w_bank      = ~r_bank;
               if (r_y_cnt < Y_END) w_y_cnt = r_y_cnt + YCW'(1);
               if (w_overrun_pend) begin
                  w_overrun_pend = 1'b0;
                  w_state        = SKIP;
               end else begin
                  w_state = WAIT;
               end
            end else begin
               w_drain = 1'b1;
               w_d_cnt = r_d_cnt + DCW'(1);
            end
         end

         SKIP: begin
            // Level test: the overlapped line may already have ended while
            // the drain window was still open.
            if (!hsync_in || !vsync_in) begin
               w_line_done = 1'b1;
               w_bank      = ~r_bank;
               if (r_y_cnt < Y_END) w_y_cnt = r_y_cnt + YCW'(1);
               w_state = WAIT;
            end
         end

         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= IDLE;
         r_x_cnt           <= '0;
         r_y_cnt           <= '0;
         r_d_cnt           <= '0;
         r_line_long_seen  <= 1'b0;
         r_frame_long_seen <= 1'b0;
         r_overrun_pend    <= 1'b0;
         r_vs_fell         <= 1'b0;
         r_bank            <= 1'b0;
         r_drain           <= 1'b0;
         r_line_done       <= 1'b0;
         r_frame_done      <= 1'b0;
         r_err             <= '0;
         r_pix_valid       <= 1'b0;
         r_pix_out         <= '0;
         r_x               <= '0;
         r_y               <= '0;
         r_first_col       <= 1'b0;
         r_last_col        <= 1'b0;
         r_first_row       <= 1'b0;
         r_last_row        <= 1'b0;
      end else begin
         r_state           <= w_state;
         r_x_cnt           <= w_x_cnt;
         r_y_cnt           <= w_y_cnt;
         r_d_cnt           <= w_d_cnt;
         r_line_long_seen  <= w_line_long_seen;
         r_frame_long_seen <= w_frame_long_seen;
         r_overrun_pend    <= w_overrun_pend;
         r_vs_fell         <= w_vs_fell;
         r_bank            <= w_bank;
         r_drain           <= w_drain;
         r_line_done       <= w_line_done;
         r_frame_done      <= w_frame_done;
         r_err             <= w_err;
         r_pix_valid       <= w_issue;
         r_pix_out         <= pix_in;
         // Position is captured only for issued pixels and held otherwise.
         if (w_issue) begin
            r_x <= r_x_cnt[XW-1:0];
            r_y <= r_y_cnt[YW-1:0];
         end
         r_first_col <= w_issue && (r_x_cnt == '0);
         r_last_col  <= w_issue && (r_x_cnt == X_LAST);
         r_first_row <= w_issue && (r_y_cnt == '0);
         r_last_row  <= w_issue && (r_y_cnt == Y_LAST);
      end
   end

   // ---------------------------------------------------------------- outputs
   assign pix_valid       = r_pix_valid;
   assign pix_out         = r_pix_out;
   assign x               = r_x;
   assign y               = r_y;
   assign first_col       = r_first_col;
   assign last_col        = r_last_col;
   assign first_row       = r_first_row;
   assign last_row        = r_last_row;
   assign drain           = r_drain;
   assign err_bank        = r_bank;
   assign line_done       = r_line_done;
   assign frame_done      = r_frame_done;
   assign err_line_short  = r_err[ERR_LINE_SHORT];
   assign err_line_long   = r_err[ERR_LINE_LONG];
   assign err_frame_short = r_err[ERR_FRAME_SHORT];
   assign err_frame_long  = r_err[ERR_FRAME_LONG];
   assign err_overrun     = r_err[ERR_OVERRUN];

endmodule : image_dither_sequencer

// File: tb/tb_image_dither_sequencer.sv
// -----------------------------------------------------------------------------
// tb_image_dither_sequencer
// Directed bench for image_dither_sequencer with an 8x4 image, PIPE_DEPTH=2.
// Each step drives one cycle of vsync/hsync/pixel, then samples the registered
// response 1 ns after the clock edge and accumulates event counts that are
// compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_image_dither_sequencer;

   localparam int PW = 8;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int PD = 2;
   localparam int XW = 3;
   localparam int YW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          vsync_in, hsync_in;
   logic [PW-1:0] pix_in;
   logic          pix_valid;
   logic [PW-1:0] pix_out;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          first_col, last_col, first_row, last_row;
   logic          drain, err_bank, line_done, frame_done;
   logic          err_line_short, err_line_long, err_frame_short;
   logic          err_frame_long, err_overrun;

   image_dither_sequencer #(
      .PIXWIDTH     (PW),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .PIPE_DEPTH   (PD)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .vsync_in        (vsync_in),
      .hsync_in        (hsync_in),
      .pix_in          (pix_in),
      .pix_valid       (pix_valid),
      .pix_out         (pix_out),
      .x               (x),
      .y               (y),
      .first_col       (first_col),
      .last_col        (last_col),
      .first_row       (first_row),
      .last_row        (last_row),
      .drain           (drain),
      .err_bank        (err_bank),
      .line_done       (line_done),
      .frame_done      (frame_done),
      .err_line_short  (err_line_short),
      .err_line_long   (err_line_long),
      .err_frame_short (err_frame_short),
      .err_frame_long  (err_frame_long),
      .err_overrun     (err_overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Event accumulators, cleared by clr().
   int n_valid, n_fc, n_lc, n_fr, n_lr, n_drain, n_ld, n_fd;
   int n_short, n_long, n_fshort, n_flong, n_ovr;
   int n_xbad, n_ybad, n_flagbad, n_pixbad;
   int cur_line, exp_x;
   logic [3:0] bank_seq;

   task automatic clr();
      n_valid = 0; n_fc = 0; n_lc = 0; n_fr = 0; n_lr = 0;
      n_drain = 0; n_ld = 0; n_fd = 0;
      n_short = 0; n_long = 0; n_fshort = 0; n_flong = 0; n_ovr = 0;
      n_xbad = 0; n_ybad = 0; n_flagbad = 0; n_pixbad = 0;
      bank_seq = '0;
   endtask

   task automatic step(input logic vs, input logic hs);
      vsync_in = vs;
      hsync_in = hs;
      pix_in   = PW'($urandom);
      @(posedge clk);
      #1;
      if (!reset && pix_out !== pix_in) n_pixbad++;
      if (pix_valid) begin
         n_valid++;
         if (int'(x) != exp_x) n_xbad++;
         if (int'(y) != cur_line) n_ybad++;
         if (x == '0 && cur_line < 4) bank_seq[cur_line[1:0]] = err_bank;
         exp_x++;
      end else if (first_col || last_col || first_row || last_row) begin
         n_flagbad++;
      end
      n_fc     += int'(first_col);
      n_lc     += int'(last_col);
      n_fr     += int'(first_row);
      n_lr     += int'(last_row);
      n_drain  += int'(drain);
      n_ld     += int'(line_done);
      n_fd     += int'(frame_done);
      n_short  += int'(err_line_short);
      n_long   += int'(err_line_long);
      n_fshort += int'(err_frame_short);
      n_flong  += int'(err_frame_long);
      n_ovr    += int'(err_overrun);
   endtask

   task automatic line(input int idx, input int npx, input int gap);
      cur_line = idx;
      exp_x    = 0;
      repeat (npx) step(1'b1, 1'b1);
      repeat (gap) step(1'b1, 1'b0);
   endtask

   task automatic frame_start();
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
   endtask

   task automatic frame_end();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   initial begin
      reset    = 1'b1;
      vsync_in = 1'b0;
      hsync_in = 1'b0;
      pix_in   = '0;
      cur_line = 0;
      exp_x    = 0;
      clr();

      // ---------------- reset state
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("reset_outputs",
            {pix_valid, pix_out, x, y, first_col, last_col, first_row, last_row,
             drain, err_bank, line_done, frame_done, err_line_short, err_line_long,
             err_frame_short, err_frame_long, err_overrun}, 0);
      reset = 1'b0;

      // ---------------- 1: nominal 4 x 8 frame
      clr();
      frame_start();
      for (int l = 0; l < H; l++) line(l, W, 4);
      frame_end();
      check("nom_valid",     n_valid, 32);
      check("nom_xseq",      n_xbad, 0);
      check("nom_yseq",      n_ybad, 0);
      check("nom_first_col", n_fc, 4);
      check("nom_last_col",  n_lc, 4);
      check("nom_first_row", n_fr, 8);
      check("nom_last_row",  n_lr, 8);
      check("nom_flag_gate", n_flagbad, 0);
      check("nom_drain",     n_drain, 8);
      check("nom_line_done", n_ld, 4);
      check("nom_frame_done", n_fd, 1);
      check("nom_errors",    n_short + n_long + n_fshort + n_flong + n_ovr, 0);
      check("nom_bank_seq",  bank_seq, 4'b1010);
      check("nom_pix_delay", n_pixbad, 0);

      // ---------------- 2 / 3: short and long lines
      frame_start();
      line(0, W, 4);
      clr();
      line(1, 5, 4);
      check("short_valid",     n_valid, 5);
      check("short_err",       n_short, 1);
      check("short_no_long",   n_long, 0);
      check("short_drain",     n_drain, 2);
      check("short_line_done", n_ld, 1);
      clr();
      line(2, 10, 4);
      check("long_valid",    n_valid, 8);
      check("long_err",      n_long, 1);
      check("long_no_short", n_short, 0);
      check("long_last_col", n_lc, 1);
      check("long_y_adv",    n_ybad, 0);
      check("long_xseq",     n_xbad, 0);
      line(3, W, 4);
      clr();
      frame_end();
      check("sl_frame_done",  n_fd, 1);
      check("sl_frame_short", n_fshort, 0);

      // ---------------- 4: hsync rises one cycle after the fall
      frame_start();
      clr();
      cur_line = 0;
      exp_x    = 0;
      repeat (W) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      repeat (6) step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);
      check("ovr_valid",     n_valid, 8);
      check("ovr_err",       n_ovr, 1);
      check("ovr_line_done", n_ld, 2);
      check("ovr_drain",     n_drain, 2);
      clr();
      line(2, W, 4);
      check("ovr_y_plus2", n_ybad, 0);
      check("ovr_next_valid", n_valid, 8);
      line(3, W, 4);
      clr();
      frame_end();
      check("ovr_frame_short", n_fshort, 0);

      // ---------------- 5a: 3-line frame
      clr();
      frame_start();
      for (int l = 0; l < 3; l++) line(l, W, 4);
      frame_end();
      check("f3_frame_short", n_fshort, 1);
      check("f3_frame_done",  n_fd, 1);
      check("f3_line_done",   n_ld, 3);

      // ---------------- 5b: 5-line frame
      frame_start();
      for (int l = 0; l < H; l++) line(l, W, 4);
      clr();
      line(4, W, 4);
      check("f5_valid",     n_valid, 0);
      check("f5_flong",     n_flong, 1);
      check("f5_line_done", n_ld, 1);
      clr();
      frame_end();
      check("f5_no_short",  n_fshort, 0);
      check("f5_frame_done", n_fd, 1);

      // ---------------- 6: reset in mid line
      frame_start();
      cur_line = 0;
      exp_x    = 0;
      repeat (4) step(1'b1, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b1);
      check("mid_reset_outputs",
            {pix_valid, pix_out, x, y, first_col, last_col, first_row, last_row,
             drain, err_bank, line_done, frame_done, err_line_short, err_line_long,
             err_frame_short, err_frame_long, err_overrun}, 0);
      reset = 1'b0;
      clr();
      repeat (3) step(1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("rst_no_valid", n_valid, 0);
      check("rst_no_done",  n_ld + n_fd + n_drain, 0);
      clr();
      step(1'b1, 1'b0);
      line(0, W, 4);
      check("rst_resume_valid", n_valid, 8);
      check("rst_resume_xseq",  n_xbad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_image_dither_sequencer
